// File: rtl/fpdiv_pkg.sv
// Shared types and datapath select encodings for the Goldschmidt divider controller.
package fpdiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_N,
      S_INIT_D,
      S_ITER_N,
      S_ITER_D,
      S_REM,
      S_DONE
   } state_e;

   localparam logic [1:0] MUX4_IA_N = 2'b00;
   localparam logic [1:0] MUX4_IA_D = 2'b01;
   localparam logic [1:0] MUX4_C_N  = 2'b10;
   localparam logic [1:0] MUX4_C_D  = 2'b11;

   localparam logic [1:0] MUX3_IA   = 2'b00;
   localparam logic [1:0] MUX3_C    = 2'b01;
   localparam logic [1:0] MUX3_REM  = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: initial approximation, NUM_ITER-1 refinement
// passes over numerator/denominator, a remainder step, then a one-cycle done.
module fpdiv_ctrl
   import fpdiv_pkg::*;
#(
   parameter int NUM_ITER = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       rm_in,
   output logic [1:0] sel_mux4,
   output logic [1:0] sel_mux3,
   output logic       en_a,
   output logic       en_b,
   output logic       en_rem,
   output logic       rm,
   output logic [2:0] iter,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_ITER = 3'(NUM_ITER);

   state_e     state_q, state_d;
   logic [2:0] iter_q, iter_d;
   logic       rm_q, rm_d;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      rm_d    = rm_q;
      if (abort) begin
         state_d = S_IDLE;
         iter_d  = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_INIT_N;
                  rm_d    = rm_in;
               end
            end
            S_INIT_N: state_d = S_INIT_D;
            S_INIT_D: begin
               // The initial-approximation pass counts as iteration 1.
               state_d = S_ITER_N;
               iter_d  = 3'd2;
            end
            S_ITER_N: state_d = S_ITER_D;
            S_ITER_D: begin
               if (iter_q < LAST_ITER) begin
                  state_d = S_ITER_N;
                  iter_d  = iter_q + 3'd1;
               end else begin
                  state_d = S_REM;
                  iter_d  = 3'd0;
               end
            end
            S_REM:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: begin
               state_d = S_IDLE;
               iter_d  = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         iter_q  <= 3'd0;
         rm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         rm_q    <= rm_d;
      end
   end

   always_comb begin
      sel_mux4 = MUX4_IA_N;
      sel_mux3 = MUX3_IA;
      en_a     = 1'b0;
      en_b     = 1'b0;
      en_rem   = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      iter     = 3'd0;
      case (state_q)
         S_IDLE:   busy = 1'b0;
         S_INIT_N: en_a = 1'b1;
         S_INIT_D: begin
            sel_mux4 = MUX4_IA_D;
            en_b     = 1'b1;
         end
         S_ITER_N: begin
            sel_mux4 = MUX4_C_N;
            sel_mux3 = MUX3_C;
            en_a     = 1'b1;
            iter     = iter_q;
         end
         S_ITER_D: begin
            sel_mux4 = MUX4_C_D;
            sel_mux3 = MUX3_C;
            en_b     = 1'b1;
            iter     = iter_q;
         end
         S_REM: begin
            sel_mux4 = MUX4_C_N;
            sel_mux3 = MUX3_REM;
            en_rem   = 1'b1;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign rm = rm_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench: two controllers (NUM_ITER 6 and 2) share stimulus and are
// checked every cycle against a step-count reference model.
module tb_fpdiv_ctrl;

   localparam int NI0 = 6;
   localparam int NI1 = 2;

   logic clk, reset, start, abort, rm_in;

   logic [1:0] sel_mux4_0, sel_mux3_0, sel_mux4_1, sel_mux3_1;
   logic       en_a0, en_b0, en_rem0, rm0, busy0, done0;
   logic       en_a1, en_b1, en_rem1, rm1, busy1, done1;
   logic [2:0] iter0, iter1;

   fpdiv_ctrl #(.NUM_ITER(NI0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .rm_in(rm_in),
      .sel_mux4(sel_mux4_0), .sel_mux3(sel_mux3_0), .en_a(en_a0), .en_b(en_b0),
      .en_rem(en_rem0), .rm(rm0), .iter(iter0), .busy(busy0), .done(done0)
   );

   fpdiv_ctrl #(.NUM_ITER(NI1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .rm_in(rm_in),
      .sel_mux4(sel_mux4_1), .sel_mux3(sel_mux3_1), .en_a(en_a1), .en_b(en_b1),
      .en_rem(en_rem1), .rm(rm1), .iter(iter1), .busy(busy1), .done(done1)
   );

   logic [12:0] obs0, obs1;
   assign obs0 = {sel_mux4_0, sel_mux3_0, en_a0, en_b0, en_rem0, iter0, busy0, done0, rm0};
   assign obs1 = {sel_mux4_1, sel_mux3_1, en_a1, en_b1, en_rem1, iter1, busy1, done1, rm1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [12:0] got, input logic [12:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endfunction

   // Model state: k = cycles since the accepted start (0 means idle).
   // k=1 INIT_N, k=2 INIT_D, k=3..2n refinement passes, 2n+1 REM, 2n+2 DONE.
   function automatic logic [12:0] expect_vec(input int k, input int n, input bit r);
      logic [1:0] s4 = 2'd0;
      logic [1:0] s3 = 2'd0;
      logic       ea = 1'b0, eb = 1'b0, er = 1'b0, b = 1'b0, d = 1'b0;
      logic [2:0] it = 3'd0;
      if (k == 1) ea = 1'b1;
      else if (k == 2) begin
         s4 = 2'd1; eb = 1'b1;
      end else if (k >= 3 && k <= 2 * n) begin
         s3 = 2'd1;
         if (k % 2 == 1) begin
            s4 = 2'd2; ea = 1'b1; it = 3'((k + 1) / 2);
         end else begin
            s4 = 2'd3; eb = 1'b1; it = 3'(k / 2);
         end
      end else if (k == 2 * n + 1) begin
         s4 = 2'd2; s3 = 2'd2; er = 1'b1;
      end else if (k == 2 * n + 2) d = 1'b1;
      b = (k >= 1 && k <= 2 * n + 1);
      return {s4, s3, ea, eb, er, it, b, d, r};
   endfunction

   function automatic int next_k(input int k, input int n, input bit st, input bit ab);
      if (k == 0) return (st && !ab) ? 1 : 0;
      if (ab) return 0;
      if (k == 2 * n + 2) return 0;
      return k + 1;
   endfunction

   int          k_m[2];
   bit          rm_m[2];
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         k_m[0] = 0; k_m[1] = 0;
         rm_m[0] = 1'b0; rm_m[1] = 1'b0;
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (k_m[i] == 0 && start && !abort) rm_m[i] = rm_in;
            k_m[i] = next_k(k_m[i], (i == 0) ? NI0 : NI1, start, abort);
         end
         exp_q0.push_back(expect_vec(k_m[0], NI0, rm_m[0]));
         exp_q1.push_back(expect_vec(k_m[1], NI1, rm_m[1]));
      end
   end

   // Monitor: compares whatever the model queued for this cycle, plus invariants.
   always @(negedge clk) begin
      if (!reset) begin
         if (exp_q0.size() > 0) chk("sb_n6", obs0, exp_q0.pop_front());
         if (exp_q1.size() > 0) chk("sb_n2", obs1, exp_q1.pop_front());
         if (done0) $display("op done n6 rm=%0d at %0t", rm0, $time);
         if (done1) $display("op done n2 rm=%0d at %0t", rm1, $time);
      end
      chk("onehot_n6", 13'($onehot0({en_a0, en_b0, en_rem0})), 13'd1);
      chk("onehot_n2", 13'($onehot0({en_a1, en_b1, en_rem1})), 13'd1);
      chk("busydone_n6", 13'(busy0 & done0), 13'd0);
      chk("busydone_n2", 13'(busy1 & done1), 13'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_k0(input int target, input int budget);
      int n = 0;
      while (k_m[0] != target && n < budget) begin
         tick();
         n++;
      end
      if (k_m[0] != target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_k0: step %0d required %0d within %0d cycles", k_m[0], target, budget);
      end
   endtask

   int c0, c1;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; rm_in = 1'b0;
      #1;
      chk("reset_n6", obs0, expect_vec(0, NI0, 1'b0));
      chk("reset_n2", obs1, expect_vec(0, NI1, 1'b0));
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      tick();

      // Single operation: done latency 2n+2 edges after acceptance.
      rm_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; rm_in = 1'b0;
      c0 = 0; c1 = 0;
      for (int cnt = 1; cnt <= 16; cnt++) begin
         if (done0 && c0 == 0) c0 = cnt;
         if (done1 && c1 == 0) c1 = cnt;
         tick();
      end
      chk("latency_n6", 13'(c0), 13'(2 * NI0 + 2));
      chk("latency_n2", 13'(c1), 13'(2 * NI1 + 2));
      chk("rm_hold_n6", 13'(rm0), 13'd1);
      chk("rm_hold_n2", 13'(rm1), 13'd1);

      // Abort in the denominator pass of iteration 4.
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_k0(8, 30);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", obs0, expect_vec(0, NI0, 1'b0));
      repeat (16) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (16) tick();

      // Start held high: back-to-back operations with one idle cycle between.
      start = 1'b1; rm_in = 1'b1;
      repeat (40) tick();
      start = 1'b0; rm_in = 1'b0;
      repeat (16) tick();

      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 19) == 0);
         rm_in = 1'($urandom);
         tick();
      end
      start = 1'b0; abort = 1'b0;
      repeat (20) tick();

      // Asynchronous reset between edges while in the remainder step.
      rm_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_k0(2 * NI0 + 1, 30);
      chk("rem_before_reset", 13'(en_rem0), 13'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rem_drop", 13'(en_rem0), 13'd0);
      chk("async_state_n6", obs0, expect_vec(0, NI0, 1'b0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("no_done_in_reset", 13'(done0), 13'd0);
      end
      reset = 1'b0;
      tick();
      rm_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (18) tick();
      chk("cold_rm_n6", 13'(rm0), 13'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
